// File: rtl/eth_pkg.sv
`default_nettype none
// ---- eth_pkg : shared constants and state encoding for the TX scheduler (rev 1.0) ----
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

  localparam int unsigned PORT_ARP = 0;
  localparam int unsigned PORT_UDP = 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    GO         = 3'd2,
    WAIT_START = 3'd3,
    BUSY       = 3'd4,
    IFG        = 3'd5
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_tx_sched_rr_arb2.sv
`default_nettype none
// ---- rr_arb2 : two-input round-robin arbiter, pointer moves past the served port (rev 1.0) ----
module rr_arb2
  import eth_pkg::*;
(
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       win
);

  logic ptr_q;

  assign win = req[ptr_q] ? ptr_q : ~ptr_q;

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'(PORT_ARP);
    end else if (update) begin
      ptr_q <= ~served;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_sched.sv
`default_nettype none
// ---- eth_tx_sched : arbitrates ARP/UDP frames onto eth_send with IFG and start timeout (rev 1.0) ----
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 64,
  parameter int MAX_LEN       = 1500
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  input  logic [47:0] dmac0,
  input  logic [47:0] dmac1,
  input  logic [7:0]  rddata0,
  input  logic [7:0]  rddata1,
  output logic [1:0]  rdreq,
  output logic [1:0]  grant,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        tx_go,
  output logic [15:0] data_length,
  output logic [47:0] des_mac,
  output logic [15:0] type_length,
  input  logic        fifo_rdreq,
  output logic [7:0]  fifo_rddata,
  input  logic        gmii_tx_en
);

  localparam int CNT_RANGE = (IFG_CYCLES > START_TIMEOUT) ? IFG_CYCLES : START_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_RANGE) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] IFG_LAST   = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [15:0]      MAX_LEN_W  = 16'(MAX_LEN);

  tx_state_e        state_q, state_d;
  logic             owner_q, win;
  logic [1:0]       grant_q, grant_d, done_q, done_d, err_q, err_d, owner_oh;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_en_q, armed_q, len_bad;

  rr_arb2 u_arb (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .req         (req),
    .update      (|done_d),
    .served      (owner_q),
    .win         (win)
  );

  assign owner_oh    = owner_q ? 2'b10 : 2'b01;
  assign len_bad     = (data_length == 16'd0) || (data_length > MAX_LEN_W);
  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdreq       = grant_q & {2{fifo_rdreq}};
  assign fifo_rddata = grant_q[PORT_UDP] ? rddata1 :
                       grant_q[PORT_ARP] ? rddata0 : 8'h00;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    tx_go   = 1'b0;
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          state_d = LOAD;
          grant_d = win ? 2'b10 : 2'b01;
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (len_bad) begin
          done_d  = owner_oh;
          err_d   = owner_oh;
          grant_d = 2'b00;
          state_d = IFG;
        end else begin
          state_d = GO;
        end
      end
      GO: begin
        tx_go   = 1'b1;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        // armed_q ensures a MAC enable left high from before GO is not taken as a start
        if (gmii_tx_en && armed_q) begin
          state_d = BUSY;
        end else if (cnt_q >= START_LAST) begin
          done_d  = owner_oh;
          err_d   = owner_oh;
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = IFG;
        end
      end
      BUSY: begin
        if (tx_en_q && !gmii_tx_en) begin
          done_d  = owner_oh;
          grant_d = 2'b00;
          cnt_d   = '0;
          state_d = IFG;
        end
      end
      IFG: begin
        if (cnt_q >= IFG_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      cnt_q       <= '0;
      tx_en_q     <= 1'b0;
      armed_q     <= 1'b0;
      data_length <= 16'd0;
      des_mac     <= 48'd0;
      type_length <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tx_en_q <= gmii_tx_en;
      armed_q <= ((state_q == GO) || (state_q == WAIT_START)) && (armed_q || !gmii_tx_en);
      if ((state_q == IDLE) && (|req)) begin
        owner_q <= win;
        if (win) begin
          data_length <= len1;
          des_mac     <= dmac1;
          type_length <= ETH_TYPE_IPV4;
        end else begin
          data_length <= len0;
          des_mac     <= dmac0;
          type_length <= ETH_TYPE_ARP;
        end
      end
    end
  end

endmodule
`default_nettype wire
